// File: rtl/mig_app_pkg.sv
// Shared constants and FSM encoding for the two-port MIG app arbiter.
package mig_app_pkg;

   localparam int ADDR_WIDTH_DEF     = 28;
   localparam int APP_DATA_WIDTH_DEF = 128;
   localparam int TAG_DEPTH_DEF      = 16;

   localparam logic [2:0] CMD_WRITE = 3'd0;
   localparam logic [2:0] CMD_READ  = 3'd1;

   typedef enum logic [1:0] {
      ST_CALIB = 2'd0,
      ST_ARB   = 2'd1,
      ST_ISSUE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mig_rd_tag_fifo.sv
// Read-tag FIFO: remembers which requester owns each outstanding read.
module mig_rd_tag_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     push_tag,
   input  logic                     pop,
   output logic                     pop_tag,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign pop_tag = mem[rd_ptr];

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_tag;
   end

endmodule

// File: rtl/mig_app_arbiter.sv
// Round-robin arbiter sharing one MIG app port between two requesters,
// with read data steered back to its requester through a tag FIFO.
module mig_app_arbiter
   import mig_app_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int APP_DATA_WIDTH = APP_DATA_WIDTH_DEF,
   parameter int TAG_DEPTH      = TAG_DEPTH_DEF
) (
   input  logic                        ui_clk,
   input  logic                        ui_rst,
   input  logic                        init_calib_complete,
   input  logic [1:0]                  req_en,
   input  logic [1:0]                  req_wr,
   input  logic [2*ADDR_WIDTH-1:0]     req_addr,
   input  logic [2*APP_DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]                  req_rdy,
   output logic [APP_DATA_WIDTH-1:0]   rd_data,
   output logic [1:0]                  rd_valid,
   output logic                        app_en,
   output logic                        app_wdf_wren,
   output logic                        app_wdf_end,
   output logic [2:0]                  app_cmd,
   output logic [ADDR_WIDTH-1:0]       app_addr,
   output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
   input  logic                        app_rdy,
   input  logic                        app_wdf_rdy,
   input  logic                        app_rd_data_valid,
   input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
   output logic [$clog2(TAG_DEPTH):0]  rd_pending,
   output logic                        err_orphan
);

   arb_state_t state;
   logic       grant;
   logic       last_grant;
   logic       g_en;
   logic       g_wr;
   logic       issue_ok;
   logic       tag_full;
   logic       tag_empty;
   logic       tag_out;
   logic       push;
   logic       pop;

   assign g_en = grant ? req_en[1] : req_en[0];
   assign g_wr = grant ? req_wr[1] : req_wr[0];

   // A full tag FIFO only holds back reads; writes need no tag.
   assign issue_ok = g_wr ? (app_rdy & app_wdf_rdy)
                          : (app_rdy & ~tag_full);

   assign app_en       = ~ui_rst & (state == ST_ISSUE) & g_en & issue_ok;
   assign app_wdf_wren = app_en & g_wr;
   assign app_wdf_end  = app_en & g_wr;
   assign app_cmd      = g_wr ? CMD_WRITE : CMD_READ;

   assign app_addr = grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : req_addr[ADDR_WIDTH-1:0];

   assign app_wdf_data = grant ? req_wdata[2*APP_DATA_WIDTH-1:APP_DATA_WIDTH]
                               : req_wdata[APP_DATA_WIDTH-1:0];

   assign req_rdy = grant ? {app_en, 1'b0} : {1'b0, app_en};

   assign push     = app_en & ~g_wr;
   assign pop      = ~ui_rst & app_rd_data_valid & ~tag_empty;
   assign rd_valid = {pop & tag_out, pop & ~tag_out};
   assign rd_data  = app_rd_data;

   always_ff @(posedge ui_clk) begin
      if (ui_rst) begin
         state      <= ST_CALIB;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            ST_CALIB: begin
               if (init_calib_complete) state <= ST_ARB;
            end
            ST_ARB: begin
               if (!init_calib_complete) begin
                  state <= ST_CALIB;
               end else if (|req_en) begin
                  grant <= req_en[~last_grant] ? ~last_grant : last_grant;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (app_en) begin
                  last_grant <= grant;
                  state      <= ST_ARB;
               end else if (!g_en) begin
                  state <= ST_ARB;
               end
            end
            default: state <= ST_CALIB;
         endcase
      end
   end

   always_ff @(posedge ui_clk) begin
      if (ui_rst)                                err_orphan <= 1'b0;
      else if (app_rd_data_valid && tag_empty)   err_orphan <= 1'b1;
   end

   mig_rd_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk      (ui_clk),
      .rst      (ui_rst),
      .push     (push),
      .push_tag (grant),
      .pop      (pop),
      .pop_tag  (tag_out),
      .full     (tag_full),
      .empty    (tag_empty),
      .count    (rd_pending)
   );

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Bench for mig_app_arbiter: per-cycle queue model plus directed scenarios.
module tb_mig_app_arbiter;
   import mig_app_pkg::*;

   localparam int AW = 28;
   localparam int DW = 128;

   logic            clk = 1'b0;
   logic            ui_rst;
   logic            init_calib_complete;
   logic [1:0]      req_en;
   logic [1:0]      req_wr;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [1:0]      req_rdy;
   logic [DW-1:0]   rd_data;
   logic [1:0]      rd_valid;
   logic            app_en;
   logic            app_wdf_wren;
   logic            app_wdf_end;
   logic [2:0]      app_cmd;
   logic [AW-1:0]   app_addr;
   logic [DW-1:0]   app_wdf_data;
   logic            app_rdy;
   logic            app_wdf_rdy;
   logic            app_rd_data_valid;
   logic [DW-1:0]   app_rd_data;
   logic [4:0]      rd_pending;
   logic            err_orphan;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mig_app_arbiter dut (
      .ui_clk              (clk),
      .ui_rst              (ui_rst),
      .init_calib_complete (init_calib_complete),
      .req_en              (req_en),
      .req_wr              (req_wr),
      .req_addr            (req_addr),
      .req_wdata           (req_wdata),
      .req_rdy             (req_rdy),
      .rd_data             (rd_data),
      .rd_valid            (rd_valid),
      .app_en              (app_en),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_cmd             (app_cmd),
      .app_addr            (app_addr),
      .app_wdf_data        (app_wdf_data),
      .app_rdy             (app_rdy),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data_valid   (app_rd_data_valid),
      .app_rd_data         (app_rd_data),
      .rd_pending          (rd_pending),
      .err_orphan          (err_orphan)
   );

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: a queue of requester ids for outstanding reads, a sticky
   // orphan flag, and the handshake rules each accepted command obeys.
   int q[$];
   bit m_orph   = 1'b0;
   bit prev_rst = 1'b1;
   bit prev_acc = 1'b0;

   always @(negedge clk) begin : cmp
      logic [1:0] erv;
      int         gi;
      gi = req_rdy[1] ? 1 : 0;
      if (ui_rst) begin
         chk("rst_app_en", app_en, 0);
         chk("rst_req_rdy", req_rdy, 0);
         chk("rst_rd_valid", rd_valid, 0);
         chk("rst_wren", app_wdf_wren, 0);
         q.delete();
         m_orph   = 1'b0;
         prev_acc = 1'b0;
      end else begin
         if (prev_rst) begin
            chk("post_rst_app_en", app_en, 0);
            chk("post_rst_req_rdy", req_rdy, 0);
            chk("post_rst_pending", rd_pending, 0);
            chk("post_rst_orphan", err_orphan, 0);
         end
         chk("pending", rd_pending, q.size());
         chk("orphan", err_orphan, m_orph);
         erv = 2'b00;
         if (app_rd_data_valid && q.size() > 0) erv[q[0]] = 1'b1;
         chk("rd_valid", rd_valid, erv);
         if (erv != 2'b00) chk("rd_data", rd_data, app_rd_data);
         chk("rdy_onehot", req_rdy == 2'b11, 0);
         chk("en_vs_rdy", app_en, |req_rdy);
         if (app_en) begin
            chk("cmd", app_cmd, req_wr[gi] ? 3'd0 : 3'd1);
            chk("addr", app_addr, req_addr[gi*AW +: AW]);
            chk("wren", app_wdf_wren, req_wr[gi]);
            chk("wdf_end", app_wdf_end, req_wr[gi]);
            chk("en_needs_rdy", app_rdy, 1);
            chk("en_needs_req", req_en[gi], 1);
            chk("spacing", prev_acc, 0);
            if (req_wr[gi]) begin
               chk("wdata", app_wdf_data, req_wdata[gi*DW +: DW]);
               chk("wr_needs_wdf", app_wdf_rdy, 1);
            end else begin
               chk("rd_tag_room", q.size() < 16, 1);
            end
         end else begin
            chk("idle_wren", app_wdf_wren, 0);
            chk("idle_end", app_wdf_end, 0);
         end
         if (app_rd_data_valid) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_orph = 1'b1;
         end
         if (app_en && !req_wr[gi]) q.push_back(gi);
         prev_acc = app_en;
      end
      prev_rst = ui_rst;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      ui_rst = 1'b1;
      step();
      step();
      ui_rst = 1'b0;
   endtask

   task automatic do_req(input int i, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output bit ok);
      req_wr[i]              = wr;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
      req_en[i]              = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 6 && !ok; k++) begin
         @(negedge clk);
         if (req_rdy[i]) ok = 1'b1;
         step();
      end
      req_en[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench timed out");
      $fatal(1);
   end

   initial begin
      bit ok;
      bit w_ok;
      bit r_acc;
      int n;
      int cnt;
      int grants[8];
      int cyc[8];

      ui_rst = 1'b1;
      init_calib_complete = 1'b0;
      req_en = '0;
      req_wr = '0;
      req_addr = '0;
      req_wdata = '0;
      app_rdy = 1'b1;
      app_wdf_rdy = 1'b1;
      app_rd_data_valid = 1'b0;
      app_rd_data = '0;
      step();
      reset_dut();

      @(negedge clk);
      chk("reset_pending", rd_pending, 0);
      chk("reset_orphan", err_orphan, 0);
      chk("reset_app_en", app_en, 0);
      step();

      // Calibration gating
      req_wr[0] = 1'b1;
      req_addr[AW-1:0] = 28'h0000040;
      req_wdata[DW-1:0] = 128'hC0FFEE;
      req_en = 2'b01;
      cnt = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (app_en) cnt++;
         step();
      end
      chk("calib_block", cnt, 0);
      init_calib_complete = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 3 && !ok; k++) begin
         @(negedge clk);
         if (req_rdy[0]) ok = 1'b1;
         step();
      end
      req_en = 2'b00;
      chk("calib_accept", ok, 1);

      // Fairness: both hold writes, grants alternate from requester 0
      reset_dut();
      req_wr = 2'b11;
      req_wdata = {128'hBBBB, 128'hAAAA};
      req_addr = {28'h0000200, 28'h0000100};
      req_en = 2'b11;
      n = 0;
      for (int k = 0; k < 40 && n < 8; k++) begin
         @(negedge clk);
         if (|req_rdy) begin
            grants[n] = req_rdy[1] ? 1 : 0;
            cyc[n] = k;
            n++;
         end
         step();
      end
      req_en = 2'b00;
      chk("fair_count", n, 8);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("fair_grant%0d", k), grants[k], k % 2);
         if (k > 0) chk($sformatf("fair_gap%0d", k), cyc[k] - cyc[k-1], 2);
      end

      // Read routing
      do_req(0, 1'b0, 28'h08, '0, ok);
      chk("rd0_accept", ok, 1);
      do_req(1, 1'b0, 28'h10, '0, ok);
      chk("rd1_accept", ok, 1);
      @(negedge clk);
      chk("route_pending2", rd_pending, 2);
      step();
      app_rd_data = 128'hAAAA_0001;
      app_rd_data_valid = 1'b1;
      @(negedge clk);
      chk("route_a_valid", rd_valid, 2'b01);
      chk("route_a_data", rd_data, 128'hAAAA_0001);
      step();
      app_rd_data = 128'hBBBB_0002;
      @(negedge clk);
      chk("route_b_valid", rd_valid, 2'b10);
      chk("route_b_data", rd_data, 128'hBBBB_0002);
      step();
      app_rd_data_valid = 1'b0;
      @(negedge clk);
      chk("route_pending0", rd_pending, 0);
      step();

      // Tag FIFO full
      for (int k = 0; k < 16; k++) begin
         do_req(0, 1'b0, AW'(k * 8), '0, ok);
         chk($sformatf("fill_rd%0d", k), ok, 1);
      end
      @(negedge clk);
      chk("full_pending16", rd_pending, 16);
      step();
      req_wr = 2'b10;
      req_addr = {28'h0000300, 28'h0000400};
      req_wdata[2*DW-1:DW] = 128'h5EED;
      req_en = 2'b11;
      w_ok = 1'b0;
      r_acc = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (req_rdy[1]) w_ok = 1'b1;
         if (req_rdy[0]) r_acc = 1'b1;
         step();
         if (w_ok) req_en[1] = 1'b0;
      end
      chk("full_write_ok", w_ok, 1);
      chk("full_read_stall", r_acc, 0);
      app_rd_data = 128'h1234;
      app_rd_data_valid = 1'b1;
      @(negedge clk);
      chk("full_ret_valid", rd_valid, 2'b01);
      chk("full_ret_nordy", req_rdy, 2'b00);
      step();
      app_rd_data_valid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 4 && !ok; k++) begin
         @(negedge clk);
         if (req_rdy[0]) ok = 1'b1;
         step();
      end
      req_en = 2'b00;
      chk("full_read_resume", ok, 1);

      // Drain while requester 1 keeps reading: push and pop overlap
      req_wr[1] = 1'b0;
      req_addr[2*AW-1:AW] = 28'h0000500;
      req_en = 2'b10;
      app_rd_data_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         app_rd_data = DW'(k + 100);
         step();
      end
      req_en = 2'b00;
      for (int k = 0; k < 40; k++) begin
         app_rd_data_valid = (rd_pending != 0);
         if (rd_pending == 0) break;
         step();
      end
      app_rd_data_valid = 1'b0;
      @(negedge clk);
      chk("drain_pending0", rd_pending, 0);
      chk("drain_no_orphan", err_orphan, 0);
      step();

      // Orphan return
      app_rd_data_valid = 1'b1;
      @(negedge clk);
      chk("orphan_no_valid", rd_valid, 2'b00);
      step();
      app_rd_data_valid = 1'b0;
      @(negedge clk);
      chk("orphan_set", err_orphan, 1);
      step();
      step();
      @(negedge clk);
      chk("orphan_sticky", err_orphan, 1);
      step();

      // Reset while a write waits in ISSUE
      do_req(1, 1'b0, 28'h20, '0, ok);
      do_req(1, 1'b0, 28'h28, '0, ok);
      @(negedge clk);
      chk("pre_rst_pending", rd_pending, 2);
      step();
      app_rdy = 1'b0;
      req_wr[0] = 1'b1;
      req_en = 2'b01;
      step();
      step();
      step();
      @(negedge clk);
      chk("stall_no_accept", req_rdy, 2'b00);
      step();
      ui_rst = 1'b1;
      app_rdy = 1'b1;
      @(negedge clk);
      chk("mid_rst_app_en", app_en, 0);
      chk("mid_rst_req_rdy", req_rdy, 2'b00);
      step();
      ui_rst = 1'b0;
      @(negedge clk);
      chk("after_rst_state", dut.state, ST_CALIB);
      chk("after_rst_pending", rd_pending, 0);
      chk("after_rst_orphan", err_orphan, 0);
      chk("after_rst_app_en", app_en, 0);
      step();
      req_en = 2'b00;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mig_app_arbiter.md
MIG_APP_ARBITER -- requirements
Module: mig_app_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 28, the MIG app_addr width.
REQ-002 SHALL have parameter APP_DATA_WIDTH, default 128, the app data width (16-bit bus x BL8).
REQ-003 SHALL have parameter TAG_DEPTH, default 16, the read-tag FIFO depth (power of 2).
REQ-004 One clock; reset is synchronous and active-high. Ports: ui_clk input 1, the sole clock (MIG ui_clk); ui_rst input 1, sync active-high reset (MIG ui_clk_sync_rst).
REQ-005 init_calib_complete  input  1  MIG calibration done.
REQ-006 req_en  input  2  per-requester command request, held until accepted.
REQ-007 req_wr  input  2  per-requester: 1 = write, 0 = read.
REQ-008 req_addr  input  2xADDR_WIDTH  per-requester address.
REQ-009 req_wdata  input  2xAPP_DATA_WIDTH  per-requester write data.
REQ-010 req_rdy  output  2  per-requester accept pulse; accept = req_en[i] & req_rdy[i].
REQ-011 rd_data  output  APP_DATA_WIDTH  app_rd_data broadcast to both requesters.
REQ-012 rd_valid  output  2  one-hot read-data valid, routed by tag.
REQ-013 app_en, app_wdf_wren, app_wdf_end  output  1 each  MIG command/write strobes.
REQ-014 app_cmd  output  3  3'd0 write, 3'd1 read.
REQ-015 app_addr  output  ADDR_WIDTH;  app_wdf_data  output  APP_DATA_WIDTH.
REQ-016 app_rdy, app_wdf_rdy, app_rd_data_valid  input  1 each;  app_rd_data  input  APP_DATA_WIDTH.
REQ-017 rd_pending  output  $clog2(TAG_DEPTH)+1  outstanding read count.
REQ-018 err_orphan  output  1  sticky: read data returned with no outstanding tag.

Function
REQ-019 FSM states: CALIB, ARB, ISSUE; CALIB -> ARB when init_calib_complete=1.
REQ-020 ARB: if any req_en, SHALL register grant g (round-robin, priority to requester != last_grant) and go ISSUE; else stay; if init_calib_complete=0, go CALIB.
REQ-021 ISSUE, write: app_en = app_wdf_wren = app_wdf_end = req_en[g] & app_rdy & app_wdf_rdy.
REQ-022 ISSUE, read: app_en = req_en[g] & app_rdy & ~tag_full; wren/end = 0.
REQ-023 app_cmd/app_addr/app_wdf_data SHALL mux requester g combinationally; req_rdy[g] = app_en in ISSUE; req_rdy = 0 otherwise.
REQ-024 On accept: last_grant <= g, return to ARB; one command per 2 cycles maximum.
REQ-025 If req_en[g] drops in ISSUE before acceptance, SHALL return to ARB without issuing.
REQ-026 Read accept SHALL push g into tag FIFO; app_rd_data_valid SHALL pop it, with rd_valid[tag]=1 the same cycle (zero latency from app_rd_data_valid).
REQ-027 Simultaneous push and pop: rd_pending unchanged, both take effect.
REQ-028 app_rd_data_valid with FIFO empty: no rd_valid, err_orphan <= 1 (sticky until reset).
REQ-029 tag_full (rd_pending == TAG_DEPTH) SHALL block reads only; writes proceed.
REQ-030 FIFO pointers SHALL wrap modulo TAG_DEPTH.

Reset
REQ-031 ui_rst=1 SHALL force state CALIB, last_grant=1 (requester 0 first), FIFO empty, rd_pending=0, err_orphan=0.
REQ-032 During and one cycle after reset: app_en, app_wdf_wren, app_wdf_end, req_rdy, rd_valid = 0; reset mid-ISSUE SHALL drop the command with no accept.

Structure
REQ-033 Package mig_app_pkg SHALL hold ADDR_WIDTH/APP_DATA_WIDTH defaults, CMD_WRITE=3'd0, CMD_READ=3'd1, FSM state encodings.
REQ-034 Tag FIFO SHALL be sub-module mig_rd_tag_fifo (1-bit data, TAG_DEPTH, full/empty/count).

Verification
REQ-035 Calib gating: req_en=2'b01, init_calib_complete=0 for 50 cycles -> app_en never 1; set to 1 -> write accepted within 3 cycles.
REQ-036 Fairness: both requesters hold write requests, app_rdy=app_wdf_rdy=1 -> grants alternate 0,1,0,1 over 8 accepts.
REQ-037 Read routing: req0 reads addr 0x08, req1 reads 0x10; MIG returns data A then B -> rd_valid=2'b01 with A, then 2'b10 with B.
REQ-038 Full: 16 reads outstanding -> 17th read stalls, write from other requester still accepted; one return -> read accepted.
REQ-039 Orphan: app_rd_data_valid pulse with rd_pending=0 -> err_orphan=1, rd_valid=0.
REQ-040 Reset mid-ISSUE with app_rdy=0 -> no accept, rd_pending=0, state CALIB.
